// File: rtl/rv32_dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding
// and the set of byte-enable patterns the responder will service.
package rv32_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int BE_LEGAL_N = 7;
  localparam logic [3:0] BE_LEGAL [BE_LEGAL_N] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  // Byte, aligned halfword, or full word only; 0000 is rejected.
  function automatic bit be_is_legal(input logic [3:0] be);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < BE_LEGAL_N; k++)
      if (be == BE_LEGAL[k]) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/rv32_mod_bytewise_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// The array is never reset; rdata only updates on a read (en with we==0).
module rv32_mod_bytewise_ram #(
  parameter  int WORDS = 1024,
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rv32_mod_dmem_responder.sv
// Target side of the dext_* bus: captures one request, counts wait states,
// then returns a single-cycle ack (with read data) or err from a byte-writable RAM.
module rv32_mod_dmem_responder
  import rv32_dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dext_req,
  input  logic        dext_wr,
  input  logic [3:0]  dext_be,
  input  logic [31:0] dext_addr,
  input  logic [31:0] dext_do,
  output logic        dext_ack,
  output logic        dext_err,
  output logic [31:0] dext_di,
  output logic        busy,
  output logic        overlap_err
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);

  dmem_state_e   r_state, w_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_wr, r_bad, r_ovf;
  logic [3:0]    r_be;
  logic [31:0]   r_do;
  logic [AW-1:0] r_idx;

  logic [31:0]   w_off;
  logic          w_bad_in, w_cap;
  logic [AW-1:0] w_idx_in, w_ram_addr;
  logic          w_src_bad, w_src_wr, w_rd_issue, w_commit, w_ram_en;
  logic [3:0]    w_ram_we;
  logic [31:0]   w_rdata;

  // Unsigned offset wraps for addresses below the base, so one compare covers both ends.
  assign w_off    = dext_addr - ADDR_BASE;
  assign w_bad_in = (w_off >= SPAN) || (dext_addr[1:0] != 2'b00) || !be_is_legal(dext_be);
  assign w_idx_in = w_off[AW+1:2];
  assign w_cap    = (r_state == IDLE) && dext_req;

  // With zero wait states the read must be launched on the capture edge,
  // so in IDLE the RAM is steered straight from the bus.
  assign w_ram_addr = (r_state == IDLE) ? w_idx_in : r_idx;
  assign w_src_bad  = (r_state == IDLE) ? w_bad_in : r_bad;
  assign w_src_wr   = (r_state == IDLE) ? dext_wr  : r_wr;
  assign w_rd_issue = (w_nxt == RESP) && (r_state != RESP) && !w_src_bad && !w_src_wr;
  assign w_commit   = (r_state == RESP) && r_wr && !r_bad;
  assign w_ram_en   = w_rd_issue || w_commit;
  assign w_ram_we   = w_commit ? r_be : 4'b0000;

  rv32_mod_bytewise_ram #(.WORDS(MEM_WORDS)) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (r_do),
    .rdata (w_rdata)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    dext_ack  = 1'b0;
    dext_err  = 1'b0;
    dext_di   = 32'h0;
    unique case (r_state)
      IDLE: begin
        if (dext_req) begin
          if (WAIT_STATES > 0) begin
            w_nxt     = WAIT;
            w_cnt_nxt = 4'(WAIT_STATES);
          end else begin
            w_nxt = RESP;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_nxt = RESP;
      end
      RESP: begin
        w_nxt    = IDLE;
        dext_ack = !r_bad;
        dext_err = r_bad;
        if (!r_bad && !r_wr) dext_di = w_rdata;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
      r_be    <= 4'b0000;
      r_do    <= 32'h0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap) begin
        r_wr  <= dext_wr;
        r_bad <= w_bad_in;
        r_be  <= dext_be;
        r_do  <= dext_do;
        r_idx <= w_idx_in;
      end
      if (dext_req && (r_state != IDLE)) r_ovf <= 1'b1;
    end
  end

  assign busy        = (r_state != IDLE);
  assign overlap_err = r_ovf;

endmodule
